// File: rtl/ship_motion_scheduler.sv
// ---------------------------------------------------------------------------
// ship_motion_scheduler
//
// Turns the raw left/right board buttons into one-cycle ship step strobes.
// Buttons are synchronised and debounced. Simultaneous presses are resolved
// by a "last pressed wins" preference. A small FSM then issues step_en at a
// fixed cadence. Ship motion runs on the single system clock and only
// advances when step_en is high. The fed-back ship_x keeps the ship inside
// the playfield.
//
// Optional feature macro: SHIP_RAMP_EN
//   defined   : after RAMP_STEPS same-direction steps the cadence switches
//               from PERIOD_SLOW to PERIOD_FAST.
//   undefined : the cadence is always PERIOD_SLOW.
//
// Ports
//   clk_master  in   1   system clock
//   d_reset     in   1   asynchronous active-high reset
//   btn_left    in   1   raw left button (asynchronous)
//   btn_right   in   1   raw right button (asynchronous)
//   freeze      in   1   pause / game over, halts all motion
//   ship_x      in  10   current ship top-left x (feedback)
//   step_en     out  1   one-cycle strobe: move the ship one pixel
//   step_dir    out  1   1 = right, 0 = left (0 when step_en is low)
//   moving      out  1   FSM in MOVE_L or MOVE_R
//   at_bound    out  1   requested direction is blocked by a bound
// ---------------------------------------------------------------------------
module ship_motion_scheduler #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned PERIOD_SLOW     = 400000,
    parameter int unsigned PERIOD_FAST     = 200000,
    parameter int unsigned RAMP_STEPS      = 8,
    parameter int unsigned LEFT_BOUND      = 144,
    parameter int unsigned RIGHT_BOUND     = 584,
    parameter int unsigned SHIP_W          = 24
) (
    input  logic       clk_master,
    input  logic       d_reset,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       freeze,
    input  logic [9:0] ship_x,
    output logic       step_en,
    output logic       step_dir,
    output logic       moving,
    output logic       at_bound
);

    localparam int unsigned DB_W       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned PERIOD_MAX = (PERIOD_SLOW > PERIOD_FAST) ? PERIOD_SLOW : PERIOD_FAST;
    localparam int unsigned TICK_W     = (PERIOD_MAX > 1) ? $clog2(PERIOD_MAX) : 1;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TICK_W-1:0] SLOW_LAST = TICK_W'(PERIOD_SLOW - 1);
    localparam logic [TICK_W-1:0] FAST_LAST = TICK_W'(PERIOD_FAST - 1);
    localparam logic [9:0]        MIN_X     = 10'(LEFT_BOUND);
    localparam logic [9:0]        MAX_X     = 10'(RIGHT_BOUND - SHIP_W);

    typedef enum logic [1:0] {IDLE, MOVE_L, MOVE_R, HALT} state_t;
    typedef enum logic [1:0] {REQ_NONE, REQ_L, REQ_R} req_t;

    // Index 0 = left button, index 1 = right button.
    logic [1:0]            sync0_q, sync1_q;
    logic [1:0]            deb_q, deb_d, deb_rise;
    logic [1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic                  pref_r_q, pref_r_d;      // 0 = prefer left, 1 = prefer right
    state_t                state_q, state_d;
    req_t                  req;
    logic [TICK_W-1:0]     tick_q, tick_d;
    logic                  step_prev_q;
    logic                  entering, blocked, ramp_done;
    logic [TICK_W-1:0]     period_last;

    // ---------------- synchroniser, debounce, preference ----------------
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
        deb_d    = deb_q;
        db_cnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync1_q[i] != deb_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    deb_d[i] = sync1_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
        deb_rise = deb_d & ~deb_q;

        // Pressing both buttons in the same cycle leaves the preference alone.
        pref_r_d = pref_r_q;
        if (deb_rise == 2'b01) pref_r_d = 1'b0;
        if (deb_rise == 2'b10) pref_r_d = 1'b1;
    end

    always_comb begin
        unique case (deb_q)
            2'b01:   req = REQ_L;
            2'b10:   req = REQ_R;
            2'b11:   req = pref_r_q ? REQ_R : REQ_L;
            default: req = REQ_NONE;
        endcase
    end

    // ---------------- motion FSM ----------------
    always_comb begin
        state_d = state_q;
        if (freeze) begin
            state_d = HALT;
        end else begin
            unique case (state_q)
                HALT:   state_d = IDLE;
                IDLE:   if (req == REQ_L) state_d = MOVE_L;
                        else if (req == REQ_R) state_d = MOVE_R;
                MOVE_L: if (req == REQ_NONE) state_d = IDLE;
                        else if (req == REQ_R) state_d = MOVE_R;
                MOVE_R: if (req == REQ_NONE) state_d = IDLE;
                        else if (req == REQ_L) state_d = MOVE_L;
                default: state_d = IDLE;
            endcase
        end
    end

    assign entering = (state_d == MOVE_L || state_d == MOVE_R) && (state_d != state_q);
    assign moving   = (state_q == MOVE_L) || (state_q == MOVE_R);
    assign blocked  = ((state_q == MOVE_L) && (ship_x <= MIN_X)) ||
                      ((state_q == MOVE_R) && (ship_x >= MAX_X));
    assign at_bound = ((req == REQ_L) && (ship_x <= MIN_X)) ||
                      ((req == REQ_R) && (ship_x >= MAX_X));

    // A direction change resets tick_q to 0, which could land a strobe right
    // after the last one of the old direction; step_prev_q forbids that.
    assign step_en  = moving && (tick_q == '0) && !blocked && !step_prev_q;
    assign step_dir = step_en && (state_q == MOVE_R);

`ifdef SHIP_RAMP_EN
    localparam int unsigned STEP_W = (RAMP_STEPS > 0) ? $clog2(RAMP_STEPS + 1) : 1;
    localparam logic [STEP_W-1:0] RAMP_LAST = STEP_W'(RAMP_STEPS);

    logic [STEP_W-1:0] step_cnt_q, step_cnt_d;

    always_comb begin
        step_cnt_d = step_cnt_q;
        if (entering) begin
            step_cnt_d = '0;
        end else if (step_en && (step_cnt_q != RAMP_LAST)) begin
            step_cnt_d = step_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_master or posedge d_reset) begin
        if (d_reset) step_cnt_q <= '0;
        else         step_cnt_q <= step_cnt_d;
    end

    assign ramp_done = (step_cnt_q == RAMP_LAST);
`else
    assign ramp_done = 1'b0;
`endif

    assign period_last = ramp_done ? FAST_LAST : SLOW_LAST;

    always_comb begin
        tick_d = '0;
        if (!entering && moving) begin
            tick_d = (tick_q >= period_last) ? '0 : tick_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk_master or posedge d_reset) begin
        if (d_reset) begin
            sync0_q     <= '0;
            sync1_q     <= '0;
            deb_q       <= '0;
            db_cnt_q    <= '0;
            pref_r_q    <= 1'b0;
            state_q     <= IDLE;
            tick_q      <= '0;
            step_prev_q <= 1'b0;
        end else begin
            sync0_q     <= {btn_right, btn_left};
            sync1_q     <= sync0_q;
            deb_q       <= deb_d;
            db_cnt_q    <= db_cnt_d;
            pref_r_q    <= pref_r_d;
            state_q     <= state_d;
            tick_q      <= tick_d;
            step_prev_q <= step_en;
        end
    end

endmodule

// File: tb/tb_ship_motion_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ship_motion_scheduler
//
// Directed bench for ship_motion_scheduler with small timing parameters.
// Expected strobes, as {cycle, direction}, are queued when the stimulus is
// applied. A monitor pops and compares on every cycle where step_en is high.
// ---------------------------------------------------------------------------
module tb_ship_motion_scheduler;

    localparam int DB   = 4;
    localparam int SLOW = 10;
    localparam int FAST = 5;
    localparam int RAMP = 3;
`ifdef SHIP_RAMP_EN
    localparam bit RAMP_ON = 1'b1;
`else
    localparam bit RAMP_ON = 1'b0;
`endif

    typedef struct {
        int cyc;
        bit dir;
    } step_t;

    logic       clk;
    logic       d_reset;
    logic       btn_left, btn_right, freeze;
    logic [9:0] ship_x;
    logic       step_en, step_dir, moving, at_bound;

    int    cyc = 0;
    int    n_checks = 0;
    int    n_fail = 0;
    step_t exp_q[$];

    ship_motion_scheduler #(
        .DEBOUNCE_CYCLES(DB),
        .PERIOD_SLOW    (SLOW),
        .PERIOD_FAST    (FAST),
        .RAMP_STEPS     (RAMP),
        .LEFT_BOUND     (144),
        .RIGHT_BOUND    (584),
        .SHIP_W         (24)
    ) dut (
        .clk_master(clk),
        .d_reset   (d_reset),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .freeze    (freeze),
        .ship_x    (ship_x),
        .step_en   (step_en),
        .step_dir  (step_dir),
        .moving    (moving),
        .at_bound  (at_bound)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Queue the strobes a held button produces from MOVE entry at 'first'
    // until (not including) cycle 'stop'.
    task automatic push_steps(input bit d, input int first, input int stop);
        int t;
        int sc;
        t  = first;
        sc = 0;
        while (t < stop) begin
            exp_q.push_back('{cyc: t, dir: d});
            if (RAMP_ON && sc < RAMP) sc++;
            t += (RAMP_ON && sc == RAMP) ? FAST : SLOW;
        end
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        step_t e;
        if (step_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_step: got strobe dir=%0d at cycle %0d expected none", step_dir, cyc);
            end else begin
                e = exp_q.pop_front();
                check("step_cycle", cyc, e.cyc);
                check("step_dir", {31'b0, step_dir}, {31'b0, e.dir});
            end
        end
    end

    localparam int C0 = 40;
    localparam int B0 = 130;

    initial begin
        d_reset   = 1'b1;
        btn_left  = 1'b0;
        btn_right = 1'b0;
        freeze    = 1'b0;
        ship_x    = 10'd300;

        // Reset state
        wait_to(2);
        check("rst_step_en", step_en, 0);
        check("rst_step_dir", step_dir, 0);
        check("rst_moving", moving, 0);
        check("rst_at_bound", at_bound, 0);
        d_reset = 1'b0;

        // Glitch shorter than the debounce window
        wait_to(10);
        btn_left = 1'b1;
        wait_to(13);
        btn_left = 1'b0;
        wait_to(30);
        check("glitch_moving", moving, 0);
        check("glitch_at_bound", at_bound, 0);

        // Hold right: MOVE_R 7 cycles after the pin edge, slow then fast cadence
        wait_to(C0);
        btn_right = 1'b1;
        push_steps(1'b1, C0 + 7, C0 + 45);
        wait_to(C0 + 6);
        check("pre_move_moving", moving, 0);
        wait_to(C0 + 7);
        check("move_r_entry", moving, 1);

        // Press left while right held: straight to MOVE_L, ramp restarts
        wait_to(C0 + 38);
        btn_left = 1'b1;
        push_steps(1'b0, C0 + 45, C0 + 79);
        wait_to(C0 + 44);
        check("before_turn_moving", moving, 1);
        wait_to(C0 + 45);
        check("turn_moving", moving, 1);
        wait_to(C0 + 72);
        btn_left  = 1'b0;
        btn_right = 1'b0;
        wait_to(C0 + 85);
        check("release_idle", moving, 0);

        // Right bound at 560 blocks; 559 resumes on the next tick 0
        wait_to(B0);
        ship_x    = 10'd560;
        btn_right = 1'b1;
        wait_to(B0 + 10);
        check("bound_at_bound", at_bound, 1);
        check("bound_moving", moving, 1);
        wait_to(B0 + 20);
        ship_x = 10'd559;
        push_steps(1'b1, B0 + 27, B0 + 51);
        wait_to(B0 + 21);
        check("unbound_at_bound", at_bound, 0);

        // Freeze mid-MOVE_R
        wait_to(B0 + 50);
        freeze = 1'b1;
        wait_to(B0 + 51);
        check("halt_moving", moving, 0);
        wait_to(B0 + 60);
        freeze = 1'b0;
        push_steps(1'b1, B0 + 62, B0 + 82);
        wait_to(B0 + 61);
        check("unfreeze_idle", moving, 0);
        wait_to(B0 + 62);
        check("unfreeze_move", moving, 1);

        // Turn left, then reset asynchronously during the first MOVE_L strobe
        wait_to(B0 + 75);
        btn_left = 1'b1;
        push_steps(1'b0, B0 + 82, B0 + 83);
        wait_to(B0 + 82);
        check("pre_reset_moving", moving, 1);
        #2;
        d_reset = 1'b1;
        #1;
        check("async_rst_step_en", step_en, 0);
        check("async_rst_moving", moving, 0);
        check("async_rst_at_bound", at_bound, 0);
        btn_left  = 1'b0;
        btn_right = 1'b0;
        wait_to(B0 + 86);
        d_reset = 1'b0;
        wait_to(B0 + 96);
        check("post_reset_idle", moving, 0);
        check("queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
